// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared constants, mixer FSM state type and the quarter-wave sine table
// generator used by the voice mixer and its ROM.
// No ports (package).
// ---------------------------------------------------------------------------
package synth_pkg;

  localparam int NUM_VOICES = 8;   // voices scanned per audio sample
  localparam int PHASE_W    = 32;  // phase accumulator word width
  localparam int LUT_ADDR_W = 8;   // quarter-wave ROM address width
  localparam int SAMPLE_W   = 16;  // signed mixed sample width
  localparam int ACC_W      = SAMPLE_W + 3;
  localparam int ROM_W      = SAMPLE_W - 1;
  localparam int ROM_DEPTH  = 1 << LUT_ADDR_W;
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  // Phase bits that matter: 2 quadrant bits plus the ROM index bits
  localparam int SNAP_W     = LUT_ADDR_W + 2;
  localparam int SAMPLE_MAX = (1 << (SAMPLE_W - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mixer_state_t;

  // round(SAMPLE_MAX * sin(pi/2 * (entry + 0.5) / ROM_DEPTH)), evaluated at
  // elaboration. The Taylor series is carried far enough (x^23) that the
  // truncation error is far below the rounding step.
  function automatic logic [ROM_W-1:0] quarter_sine(input int entry);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * (real'(entry) + 0.5) / real'(ROM_DEPTH);
    term = x;
    sum  = x;
    for (int n = 1; n <= 11; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return ROM_W'($rtoi(real'(SAMPLE_MAX) * sum + 0.5));
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// ---------------------------------------------------------------------------
// sine_quarter_rom
// 256 x 15-bit quarter-wave sine table with a registered read port
// (one clock of latency). Contents are computed at elaboration.
// Ports:
//   clk_in   - system clock
//   rst_in   - asynchronous, active-high reset (clears the read register)
//   addr_in  - table address
//   data_out - unsigned sine magnitude for the address of the previous clock
// ---------------------------------------------------------------------------
module sine_quarter_rom
  import synth_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LUT_ADDR_W-1:0] addr_in,
  output logic [ROM_W-1:0]      data_out
);

  logic [ROM_W-1:0] table_s [ROM_DEPTH];
  logic [ROM_W-1:0] data_q;

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_entry
    localparam logic [ROM_W-1:0] ENTRY = quarter_sine(g);
    assign table_s[g] = ENTRY;
  end

  // Registered table read
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q <= {ROM_W{1'b0}};
    end else begin
      data_q <= table_s[addr_in];
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/sine_voice_mixer.sv
// ---------------------------------------------------------------------------
// sine_voice_mixer
// On each audio sample tick, snapshots the voice phases and gates, turns each
// gated voice into a signed sine sample through one shared quarter-wave ROM,
// sums them and presents one scaled signed sample with a one-cycle valid.
// Latency from the tick edge to sample_valid_out is 11 clocks.
// Build option: define MIXER_SAT_EN for sum>>>1 with saturation to
// +/-32767; by default the output is sum>>>3 (never clips).
// Ports:
//   clk_in           - system clock
//   rst_in           - asynchronous, active-high reset
//   sample_tick_in   - one-cycle audio-rate strobe
//   gate_in          - per-voice active flags
//   phase_in         - per-voice accumulated phase
//   sample_out       - signed mixed sample, held between updates
//   sample_valid_out - one-cycle pulse when sample_out updates
//   busy_out         - high while a mix is in progress
//   overrun_out      - sticky: a tick arrived while busy
// ---------------------------------------------------------------------------
module sine_voice_mixer
  import synth_pkg::*;
(
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                sample_tick_in,
  input  logic [NUM_VOICES-1:0]               gate_in,
  input  logic [NUM_VOICES-1:0][PHASE_W-1:0]  phase_in,
  output logic signed [SAMPLE_W-1:0]          sample_out,
  output logic                                sample_valid_out,
  output logic                                busy_out,
  output logic                                overrun_out
);

  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);
  localparam logic [VIDX_W-1:0] DRAIN_LAST = VIDX_W'(1);

  mixer_state_t                       state_q, state_d;
  logic [VIDX_W-1:0]                  idx_q, idx_d;
  logic [NUM_VOICES-1:0][SNAP_W-1:0]  snap_q, snap_d;
  logic [NUM_VOICES-1:0]              gate_snap_q;
  logic                               start_s;
  logic                               unused_phase_s;
  logic [SNAP_W-1:0]                  cur_s;
  logic [LUT_ADDR_W-1:0]              rom_addr_s;
  logic [ROM_W-1:0]                   rom_data_s;
  logic                               pipe_vld_q, pipe_sign_q, pipe_gate_q;
  logic signed [ACC_W-1:0]            mag_s, contrib_s, acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]         scaled_s, sample_q;
  logic                               valid_q, busy_q, overrun_q;

  assign start_s = (state_q == IDLE) && sample_tick_in;

  // Keep only the quadrant and ROM index bits of each phase; the fractional
  // bits below the ROM index never influence the output.
  always_comb begin
    unused_phase_s = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      snap_d[v]      = phase_in[v][PHASE_W-1 -: SNAP_W];
      unused_phase_s = unused_phase_s ^ (^phase_in[v][PHASE_W-SNAP_W-1:0]);
    end
  end

  // Odd quadrants run the quarter table backwards
  assign cur_s      = snap_q[idx_q];
  assign rom_addr_s = cur_s[LUT_ADDR_W] ? ~cur_s[LUT_ADDR_W-1:0] : cur_s[LUT_ADDR_W-1:0];

  sine_quarter_rom u_rom (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .addr_in  (rom_addr_s),
    .data_out (rom_data_s)
  );

  // Sign and gate of the ROM word currently on rom_data_s
  assign mag_s = {{(ACC_W - ROM_W){1'b0}}, rom_data_s};

  // Signed voice contribution
  always_comb begin
    contrib_s = {ACC_W{1'b0}};
    if (!pipe_gate_q) begin
      contrib_s = {ACC_W{1'b0}};
    end else if (pipe_sign_q) begin
      contrib_s = -mag_s;
    end else begin
      contrib_s = mag_s;
    end
  end

  // FSM next state and voice / drain counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (sample_tick_in) begin
          state_d = SCAN;
          idx_d   = {VIDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (idx_q == LAST_VOICE) begin
          state_d = DRAIN;
          idx_d   = {VIDX_W{1'b0}};
        end else begin
          idx_d   = idx_q + VIDX_W'(1);
        end
      end
      // Two cycles: the last ROM read lands, then the last add settles
      DRAIN: begin
        if (idx_q == DRAIN_LAST) begin
          state_d = OUT;
          idx_d   = {VIDX_W{1'b0}};
        end else begin
          idx_d   = idx_q + VIDX_W'(1);
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = {VIDX_W{1'b0}};
      end
    endcase
  end

  // Accumulator next value
  always_comb begin
    acc_d = acc_q;
    if (start_s) begin
      acc_d = {ACC_W{1'b0}};
    end else if (pipe_vld_q) begin
      acc_d = acc_q + contrib_s;
    end else begin
      acc_d = acc_q;
    end
  end

`ifdef MIXER_SAT_EN
  localparam logic signed [ACC_W-2:0] SAT_HI = (ACC_W - 1)'(SAMPLE_MAX);
  logic signed [ACC_W-2:0] half_s;

  // Gain of 4 relative to the default build, clipped symmetrically
  always_comb begin
    half_s = (ACC_W - 1)'(acc_q >>> 1);
    if (half_s > SAT_HI) begin
      scaled_s = SAMPLE_W'(SAMPLE_MAX);
    end else if (half_s < -SAT_HI) begin
      scaled_s = SAMPLE_W'(-SAMPLE_MAX);
    end else begin
      scaled_s = SAMPLE_W'(half_s);
    end
  end
`else
  // Eight full-scale voices shifted down by 3 fit exactly in +/-32767
  always_comb begin
    scaled_s = SAMPLE_W'(acc_q >>> 3);
  end
`endif

  // FSM, counter and accumulator registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= {VIDX_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Input snapshot, taken only when a tick is accepted
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      snap_q      <= {(NUM_VOICES * SNAP_W){1'b0}};
      gate_snap_q <= {NUM_VOICES{1'b0}};
    end else if (start_s) begin
      snap_q      <= snap_d;
      gate_snap_q <= gate_in;
    end else begin
      snap_q      <= snap_q;
      gate_snap_q <= gate_snap_q;
    end
  end

  // Sign/gate pipeline aligned with the ROM's one-clock read latency
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_vld_q  <= 1'b0;
      pipe_sign_q <= 1'b0;
      pipe_gate_q <= 1'b0;
    end else begin
      pipe_vld_q  <= (state_q == SCAN);
      pipe_sign_q <= cur_s[SNAP_W-1];
      pipe_gate_q <= gate_snap_q[idx_q];
    end
  end

  // Output registers: the sample is loaded on the edge entering OUT so the
  // valid pulse coincides with the OUT cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_q  <= {SAMPLE_W{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= (state_d == OUT) ? scaled_s : sample_q;
      valid_q   <= (state_d == OUT);
      busy_q    <= (state_d != IDLE);
      overrun_q <= overrun_q | (sample_tick_in && (state_q != IDLE));
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_sine_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_sine_voice_mixer
// Self-checking bench for sine_voice_mixer: a table of directed vectors,
// randomized mixes checked against a sine-based reference model, and
// hand-written sequences for overrun, back-to-back ticks and mid-mix reset.
// Honours MIXER_SAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sine_voice_mixer;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    tick;
  logic [7:0]              gate;
  logic [7:0][31:0]        phase;
  logic signed [15:0]      sample;
  logic                    valid;
  logic                    busy;
  logic                    overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vq[$];
  int sq[$];

  always #5 clk = ~clk;

  sine_voice_mixer dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_tick_in   (tick),
    .gate_in          (gate),
    .phase_in         (phase),
    .sample_out       (sample),
    .sample_valid_out (valid),
    .busy_out         (busy),
    .overrun_out      (overrun)
  );

  // Cycle index: during the cycle after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Log every valid pulse with its cycle and value
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(cyc);
      sq.push_back(int'(sample));
    end
  end

  typedef struct packed {
    logic [7:0]  gate;
    logic [31:0] ph_all;
    logic [31:0] ph0;
    logic [31:0] ph1;
    int          exp_def;
    int          exp_sat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One voice: sign(sin) * round(32767*|sin|) at the centre of the
  // 1024-step phase bucket selected by the top 10 phase bits.
  function automatic int ref_voice(input logic [31:0] ph);
    real theta;
    real s;
    int  mag;
    theta = 2.0 * 3.14159265358979323846 * (real'(ph[31:22]) + 0.5) / 1024.0;
    s     = $sin(theta);
    mag   = $rtoi(32767.0 * ((s < 0.0) ? -s : s) + 0.5);
    return (s < 0.0) ? -mag : mag;
  endfunction

  function automatic int ref_mix(input logic [7:0] g, input logic [31:0] p [8]);
    int sum;
    int r;
    sum = 0;
    for (int v = 0; v < 8; v++) begin
      if (g[v]) sum += ref_voice(p[v]);
    end
`ifdef MIXER_SAT_EN
    r = $rtoi($floor(real'(sum) / 2.0));
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
`else
    r = $rtoi($floor(real'(sum) / 8.0));
`endif
    return r;
  endfunction

  function automatic int pick(input int e_def, input int e_sat);
`ifdef MIXER_SAT_EN
    return e_sat;
`else
    return e_def;
`endif
  endfunction

  task automatic apply(input logic [7:0] g, input logic [31:0] p [8]);
    gate = g;
    for (int v = 0; v < 8; v++) phase[v] = p[v];
  endtask

  task automatic scramble();
    gate = 8'($urandom);
    for (int v = 0; v < 8; v++) phase[v] = $urandom;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of T+12,
  // so consecutive calls place the next tick exactly at T+12.
  task automatic do_mix(input string name, input logic [7:0] g,
                        input logic [31:0] p [8], input int exp);
    int t;
    vq.delete();
    sq.delete();
    apply(g, p);
    tick = 1'b1;
    t    = cyc;
    @(negedge clk);
    tick = 1'b0;
    check({name, "/busy_T1"}, int'(busy), 1);
    scramble();
    repeat (10) @(negedge clk);
    check({name, "/valid_T11"}, int'(valid), 1);
    check({name, "/busy_T11"}, int'(busy), 1);
    @(negedge clk);
    check({name, "/busy_T12"}, int'(busy), 0);
    check({name, "/valid_T12"}, int'(valid), 0);
    check({name, "/pulses"}, vq.size(), 1);
    if (vq.size() >= 1) begin
      check({name, "/latency"}, vq[0] - t, 11);
      check({name, "/sample"}, sq[0], exp);
    end
  endtask

  logic [31:0] pv [8];
  logic [7:0]  gv;
  int          t0;
  int          exp_v;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    tick  = 1'b0;
    gate  = 8'h00;
    phase = '0;

    vecs = '{
      '{8'h00, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 0, 0},
      '{8'h01, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 4095, 16383},
      '{8'hFF, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32767, 32767},
      '{8'hFF, 32'hBFC0_0000, 32'hBFC0_0000, 32'hBFC0_0000, -32767, -32767},
      '{8'h03, 32'h3FC0_0000, 32'h0000_0000, 32'h8000_0000, 0, 0},
      '{8'h01, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 4095, 16383},
      '{8'h01, 32'h0000_0000, 32'hC000_0000, 32'h0000_0000, -4096, -16384},
      '{8'h01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 12, 50},
      '{8'h02, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, -13, -51},
      '{8'h0F, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 16383, 32767}
    };

    repeat (3) @(negedge clk);
    check("reset/sample", int'(sample), 0);
    check("reset/valid", int'(valid), 0);
    check("reset/busy", int'(busy), 0);
    check("reset/overrun", int'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, issued back to back (each tick at T+12 of the last)
    for (int i = 0; i < 10; i++) begin
      for (int v = 0; v < 8; v++) pv[v] = vecs[i].ph_all;
      pv[0] = vecs[i].ph0;
      pv[1] = vecs[i].ph1;
      do_mix($sformatf("vec%0d", i), vecs[i].gate, pv,
             pick(vecs[i].exp_def, vecs[i].exp_sat));
    end

    // Randomized mixes against the reference model
    for (int i = 0; i < 20; i++) begin
      gv = 8'($urandom);
      for (int v = 0; v < 8; v++) pv[v] = $urandom;
      do_mix($sformatf("rnd%0d", i), gv, pv, ref_mix(gv, pv));
    end
    check("b2b/overrun", int'(overrun), 0);

    // Tick in the same cycle as the valid pulse is an overrun and is dropped
    for (int v = 0; v < 8; v++) pv[v] = 32'h3FC0_0000;
    apply(8'h01, pv);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (10) @(negedge clk);
    check("ovr11/valid", int'(valid), 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("ovr11/overrun", int'(overrun), 1);
    check("ovr11/busy", int'(busy), 0);
    reset_dut();
    check("ovr11/cleared", int'(overrun), 0);

    // Second tick at T+5 with changed inputs: ignored, one pulse, sticky flag
    vq.delete();
    sq.delete();
    apply(8'h01, pv);
    tick = 1'b1;
    t0   = cyc;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    for (int v = 0; v < 8; v++) pv[v] = 32'hBFC0_0000;
    apply(8'hFF, pv);
    @(negedge clk);
    tick = 1'b0;
    check("ovr5/overrun", int'(overrun), 1);
    repeat (17) @(negedge clk);
    check("ovr5/pulses", vq.size(), 1);
    if (vq.size() >= 1) begin
      check("ovr5/latency", vq[0] - t0, 11);
      check("ovr5/sample", sq[0], pick(4095, 16383));
    end
    check("ovr5/held", int'(overrun), 1);
    check("ovr5/busy", int'(busy), 0);

    // Reset in the middle of a mix
    vq.delete();
    sq.delete();
    for (int v = 0; v < 8; v++) pv[v] = 32'h3FC0_0000;
    apply(8'hFF, pv);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst/sample", int'(sample), 0);
    check("midrst/valid", int'(valid), 0);
    check("midrst/busy", int'(busy), 0);
    check("midrst/overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst/no_pulse", vq.size(), 0);
    for (int v = 0; v < 8; v++) pv[v] = 32'h0000_0000;
    pv[0] = 32'hC000_0000;
    do_mix("after_rst", 8'h01, pv, pick(-4096, -16384));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
